// File: rtl/bp_be_hazard_tracker.sv
// Backend issue hazard tracker.
// Follows in-flight register writers through a short pipeline shadow and a
// scoreboard for late writers. From these it decides whether the instruction
// waiting in issue may dispatch this cycle.
//
// Handshake: dispatch_ok_o is a purely combinational "ready" toward issue.
// dispatch_v_i is the matching "valid" and may only be asserted in a cycle
// where dispatch_ok_o is high. Both are sampled at the rising edge of clk_i.
// The tracker still records a dispatch that breaks this rule, and the
// embedded assertion reports it in simulation.
module bp_be_hazard_tracker #(
    parameter int depth_p          = 4,
    parameter int num_rs_p         = 3,
    parameter int reg_addr_width_p = 5,
    parameter int cnt_width_p      = 32,
    localparam int tag_w_lp        = reg_addr_width_p + 1,
    localparam int rdy_w_lp        = $clog2(depth_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic                           isd_v_i,
    input  logic [num_rs_p-1:0]            isd_rs_v_i,
    input  logic [num_rs_p*tag_w_lp-1:0]   isd_rs_tag_i,
    input  logic                           isd_rd_v_i,
    input  logic [tag_w_lp-1:0]            isd_rd_tag_i,
    input  logic                           struct_stall_i,
    input  logic                           dispatch_v_i,
    input  logic                           dispatch_rd_v_i,
    input  logic [tag_w_lp-1:0]            dispatch_rd_tag_i,
    input  logic [rdy_w_lp-1:0]            dispatch_ready_i,
    input  logic                           wb_clear_v_i,
    input  logic [tag_w_lp-1:0]            wb_clear_tag_i,
    output logic                           dispatch_ok_o,
    output logic                           raw_haz_o,
    output logic                           waw_haz_o,
    output logic                           sb_busy_o,
    output logic [cnt_width_p-1:0]         stall_cnt_o
);

    // A ready index equal to depth_p marks a late (scoreboarded) writer.
    localparam logic [rdy_w_lp-1:0] late_rdy_lp = rdy_w_lp'(depth_p);
    localparam int                  sb_size_lp  = 1 << tag_w_lp;

    logic [depth_p-1:0]                stage_v_q,   stage_v_d;
    logic [depth_p-1:0][tag_w_lp-1:0]  stage_tag_q, stage_tag_d;
    logic [depth_p-1:0][rdy_w_lp-1:0]  stage_rdy_q, stage_rdy_d;
    logic [sb_size_lp-1:0]             sb_q,        sb_d;
    logic [cnt_width_p-1:0]            stall_cnt_q, stall_cnt_d;

    logic                              dispatch_wr_v;
    logic                              stage_load_v;
    logic                              sb_set_v;
    logic [num_rs_p-1:0]               rs_raw;

    // Writes to x0 are never tracked, and a flush cancels this cycle's dispatch.
    assign dispatch_wr_v = dispatch_v_i & dispatch_rd_v_i
                         & (dispatch_rd_tag_i != '0) & ~flush_i;
    assign stage_load_v  = dispatch_wr_v & (dispatch_ready_i < late_rdy_lp);
    assign sb_set_v      = dispatch_wr_v & (dispatch_ready_i == late_rdy_lp);

    // Pipeline shadow: stage 0 takes the new writer and older entries move down one stage.
    always_comb begin
        stage_v_d   = '0;
        stage_tag_d = stage_tag_q;
        stage_rdy_d = stage_rdy_q;
        for (int s = 1; s < depth_p; s++) begin
            stage_v_d[s]   = stage_v_q[s-1] & ~flush_i;
            stage_tag_d[s] = stage_tag_q[s-1];
            stage_rdy_d[s] = stage_rdy_q[s-1];
        end
        stage_v_d[0]   = stage_load_v;
        stage_tag_d[0] = dispatch_rd_tag_i;
        stage_rdy_d[0] = dispatch_ready_i;
    end

    // Scoreboard update: the set is applied after the clear, so a same-tag set wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_clear_v_i) begin
            sb_d[wb_clear_tag_i] = 1'b0;
        end
        if (sb_set_v) begin
            sb_d[dispatch_rd_tag_i] = 1'b1;
        end
    end

    // Per-source RAW: a stage holds a result that is not yet forwardable, or the scoreboard bit is set.
    always_comb begin
        rs_raw = '0;
        for (int k = 0; k < num_rs_p; k++) begin
            for (int s = 0; s < depth_p; s++) begin
                if (stage_v_q[s]
                    && (stage_tag_q[s] == isd_rs_tag_i[k*tag_w_lp +: tag_w_lp])
                    && (rdy_w_lp'(s) < stage_rdy_q[s])) begin
                    rs_raw[k] = 1'b1;
                end
            end
            if (sb_q[isd_rs_tag_i[k*tag_w_lp +: tag_w_lp]]) begin
                rs_raw[k] = 1'b1;
            end
            if (!isd_rs_v_i[k] || (isd_rs_tag_i[k*tag_w_lp +: tag_w_lp] == '0)) begin
                rs_raw[k] = 1'b0;
            end
        end
    end

    assign raw_haz_o     = |rs_raw;
    assign waw_haz_o     = isd_rd_v_i & (isd_rd_tag_i != '0) & sb_q[isd_rd_tag_i];
    assign dispatch_ok_o = ~(raw_haz_o | waw_haz_o | struct_stall_i | flush_i);
    assign sb_busy_o     = |sb_q;
    assign stall_cnt_o   = stall_cnt_q;

    // Stall counter: counts issue cycles that are blocked and holds at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (isd_v_i && !dispatch_ok_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + cnt_width_p'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_v_q   <= '0;
            stage_tag_q <= '0;
            stage_rdy_q <= '0;
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            stage_v_q   <= stage_v_d;
            stage_tag_q <= stage_tag_d;
            stage_rdy_q <= stage_rdy_d;
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A dispatch is only legal while the tracker reports dispatch_ok_o.
    a_dispatch_legal: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) dispatch_v_i |-> dispatch_ok_o
    );

endmodule

// File: tb/tb_bp_be_hazard_tracker.sv
// Directed bench for bp_be_hazard_tracker (depth 4, 3 sources, 6-bit tags).
// A second instance with a 4-bit stall counter exercises saturation.
module tb_bp_be_hazard_tracker;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        isd_v;
    logic [2:0]  isd_rs_v;
    logic [17:0] isd_rs_tag;
    logic        isd_rd_v;
    logic [5:0]  isd_rd_tag;
    logic        struct_stall;
    logic        dispatch_v;
    logic        dispatch_rd_v;
    logic [5:0]  dispatch_rd_tag;
    logic [2:0]  dispatch_ready;
    logic        wb_clear_v;
    logic [5:0]  wb_clear_tag;

    logic        dispatch_ok, raw_haz, waw_haz, sb_busy;
    logic [31:0] stall_cnt;
    logic        c_dispatch_ok, c_raw_haz, c_waw_haz, c_sb_busy;
    logic [3:0]  c_stall_cnt;

    int errors = 0;
    int checks = 0;

    bp_be_hazard_tracker dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .flush_i           (flush),
        .isd_v_i           (isd_v),
        .isd_rs_v_i        (isd_rs_v),
        .isd_rs_tag_i      (isd_rs_tag),
        .isd_rd_v_i        (isd_rd_v),
        .isd_rd_tag_i      (isd_rd_tag),
        .struct_stall_i    (struct_stall),
        .dispatch_v_i      (dispatch_v),
        .dispatch_rd_v_i   (dispatch_rd_v),
        .dispatch_rd_tag_i (dispatch_rd_tag),
        .dispatch_ready_i  (dispatch_ready),
        .wb_clear_v_i      (wb_clear_v),
        .wb_clear_tag_i    (wb_clear_tag),
        .dispatch_ok_o     (dispatch_ok),
        .raw_haz_o         (raw_haz),
        .waw_haz_o         (waw_haz),
        .sb_busy_o         (sb_busy),
        .stall_cnt_o       (stall_cnt)
    );

    bp_be_hazard_tracker #(.cnt_width_p(4)) dut_c (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .flush_i           (flush),
        .isd_v_i           (isd_v),
        .isd_rs_v_i        (isd_rs_v),
        .isd_rs_tag_i      (isd_rs_tag),
        .isd_rd_v_i        (isd_rd_v),
        .isd_rd_tag_i      (isd_rd_tag),
        .struct_stall_i    (struct_stall),
        .dispatch_v_i      (dispatch_v),
        .dispatch_rd_v_i   (dispatch_rd_v),
        .dispatch_rd_tag_i (dispatch_rd_tag),
        .dispatch_ready_i  (dispatch_ready),
        .wb_clear_v_i      (wb_clear_v),
        .wb_clear_tag_i    (wb_clear_tag),
        .dispatch_ok_o     (c_dispatch_ok),
        .raw_haz_o         (c_raw_haz),
        .waw_haz_o         (c_waw_haz),
        .sb_busy_o         (c_sb_busy),
        .stall_cnt_o       (c_stall_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish before 100000");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_issue();
        isd_v = 1'b0; isd_rs_v = '0; isd_rs_tag = '0; isd_rd_v = 1'b0; isd_rd_tag = '0;
    endtask

    task automatic issue(input logic v, input logic [2:0] rsv, input logic [5:0] t0,
                         input logic [5:0] t1, input logic [5:0] t2,
                         input logic rdv, input logic [5:0] rdt);
        isd_v = v; isd_rs_v = rsv; isd_rs_tag = {t2, t1, t0};
        isd_rd_v = rdv; isd_rd_tag = rdt;
        #1;
    endtask

    task automatic dispatch(input logic [5:0] tag, input logic [2:0] rdy);
        dispatch_v = 1'b1; dispatch_rd_v = 1'b1; dispatch_rd_tag = tag; dispatch_ready = rdy;
    endtask

    task automatic no_dispatch();
        dispatch_v = 1'b0; dispatch_rd_v = 1'b0; dispatch_rd_tag = '0; dispatch_ready = '0;
    endtask

    task automatic wb_clear(input logic v, input logic [5:0] tag);
        wb_clear_v = v; wb_clear_tag = tag;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; struct_stall = 1'b0;
        idle_issue(); no_dispatch(); wb_clear(1'b0, 6'd0);

        // Reset: only struct_stall/flush affect dispatch_ok, counter held at 0
        struct_stall = 1'b1; isd_v = 1'b1;
        #2;
        check("rst_ok_struct", dispatch_ok, 0);
        check("rst_sb_busy", sb_busy, 0);
        step();
        check("rst_cnt", stall_cnt, 0);
        struct_stall = 1'b0; isd_v = 1'b0; flush = 1'b1;
        #1 check("rst_ok_flush", dispatch_ok, 0);
        flush = 1'b0;
        #1 check("rst_ok_idle", dispatch_ok, 1);
        step();
        reset_n = 1'b1;
        step();

        // RAW on pipeline stage, ready=2: blocked in stage 0 and 1
        dispatch(6'd5, 3'd2);
        #1 check("d5_ok", dispatch_ok, 1);
        step();
        no_dispatch();
        issue(1'b1, 3'b001, 6'd5, 6'd0, 6'd0, 1'b0, 6'd0);
        check("raw_st0", raw_haz, 1);
        check("ok_st0", dispatch_ok, 0);
        step();
        check("raw_st1", raw_haz, 1);
        step();
        check("raw_st2", raw_haz, 0);
        check("ok_st2", dispatch_ok, 1);
        step();
        check("raw_st3", raw_haz, 0);
        check("cnt_two", stall_cnt, 2);
        idle_issue();

        // ready=0 never blocks; hazard evaluated with isd_v=0 but not counted
        dispatch(6'd8, 3'd0);
        step();
        no_dispatch();
        issue(1'b0, 3'b010, 6'd0, 6'd8, 6'd0, 1'b0, 6'd0);
        check("rdy0_raw", raw_haz, 0);
        idle_issue();
        dispatch(6'd9, 3'd1);
        step();
        no_dispatch();
        issue(1'b0, 3'b010, 6'd0, 6'd9, 6'd0, 1'b0, 6'd0);
        check("nov_raw", raw_haz, 1);
        check("nov_ok", dispatch_ok, 0);
        step();
        check("rdy1_edge", raw_haz, 0);
        check("nov_cnt", stall_cnt, 2);
        idle_issue();

        // Late writer f3 (tag 35): RAW and WAW until writeback clears it
        dispatch(6'd35, 3'd4);
        #1 check("d35_ok", dispatch_ok, 1);
        step();
        no_dispatch();
        check("sb_busy_set", sb_busy, 1);
        issue(1'b1, 3'b100, 6'd0, 6'd0, 6'd35, 1'b1, 6'd35);
        check("sb_raw", raw_haz, 1);
        check("sb_waw", waw_haz, 1);
        check("sb_ok", dispatch_ok, 0);
        step(); step(); step();
        check("sb_raw_hold", raw_haz, 1);
        check("sb_waw_hold", waw_haz, 1);
        wb_clear(1'b1, 6'd35);
        #1 check("clr_same_cyc", raw_haz, 1);
        step();
        wb_clear(1'b0, 6'd0);
        #1;
        check("clr_raw", raw_haz, 0);
        check("clr_waw", waw_haz, 0);
        check("clr_sb_busy", sb_busy, 0);
        check("clr_ok", dispatch_ok, 1);
        check("cnt_six", stall_cnt, 6);
        idle_issue();

        // Same-cycle set/clear interactions
        dispatch(6'd9, 3'd4);
        step();
        dispatch(6'd7, 3'd4);
        wb_clear(1'b1, 6'd7);
        step();
        no_dispatch(); wb_clear(1'b0, 6'd0);
        issue(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd7);
        check("set_wins", waw_haz, 1);
        issue(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd9);
        check("b9_set", waw_haz, 1);
        idle_issue();
        dispatch(6'd7, 3'd4);
        wb_clear(1'b1, 6'd9);
        step();
        no_dispatch(); wb_clear(1'b0, 6'd0);
        issue(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd7);
        check("b7_kept", waw_haz, 1);
        issue(1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 1'b1, 6'd9);
        check("b9_clr", waw_haz, 0);
        idle_issue();
        wb_clear(1'b1, 6'd7);
        step();
        wb_clear(1'b0, 6'd0);
        #1 check("sb_empty", sb_busy, 0);

        // x0 is never tracked
        dispatch(6'd0, 3'd3);
        step();
        dispatch(6'd0, 3'd4);
        step();
        no_dispatch();
        issue(1'b0, 3'b001, 6'd0, 6'd0, 6'd0, 1'b1, 6'd0);
        check("x0_raw", raw_haz, 0);
        check("x0_waw", waw_haz, 0);
        check("x0_sb_busy", sb_busy, 0);
        idle_issue();

        // Flush kills pipeline entries but keeps scoreboard bits
        dispatch(6'd6, 3'd4);
        step();
        dispatch(6'd4, 3'd3);
        step();
        no_dispatch();
        issue(1'b0, 3'b001, 6'd4, 6'd0, 6'd0, 1'b0, 6'd0);
        check("x4_pre_flush", raw_haz, 1);
        flush = 1'b1;
        #1 check("flush_ok", dispatch_ok, 0);
        step();
        flush = 1'b0;
        #1 check("x4_post_flush", raw_haz, 0);
        issue(1'b0, 3'b010, 6'd4, 6'd6, 6'd0, 1'b0, 6'd0);
        check("x6_kept", raw_haz, 1);
        idle_issue();
        wb_clear(1'b1, 6'd6);
        step();
        wb_clear(1'b0, 6'd0);

        // Async reset mid-operation clears scoreboard and counter without a clock edge
        dispatch(6'd10, 3'd4);
        step();
        no_dispatch();
        #1 check("pre_rst_busy", sb_busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", sb_busy, 0);
        check("async_rst_cnt", stall_cnt, 0);
        reset_n = 1'b1;

        // Saturation of the 4-bit counter over 2^4+3 stalled cycles
        isd_v = 1'b1; struct_stall = 1'b1;
        #1 check("struct_ok", dispatch_ok, 0);
        for (int i = 0; i < 14; i++) step();
        check("cnt4_14", c_stall_cnt, 14);
        step();
        check("cnt4_15", c_stall_cnt, 15);
        for (int i = 0; i < 4; i++) step();
        check("cnt4_sat", c_stall_cnt, 15);
        check("cnt32_19", stall_cnt, 19);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cnt4", c_stall_cnt, 0);
        check("mid_rst_cnt32", stall_cnt, 0);
        #1 reset_n = 1'b1;
        step(); step();
        check("post_rst_cnt4", c_stall_cnt, 2);
        isd_v = 1'b0; struct_stall = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
